// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// icache_pkg : shared states, AXI constants and address-split helpers | rev 1.0
// ============================================================================
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS_AR = 3'd2,
    S_REFILL  = 3'd3,
    S_UNC_AR  = 3'd4,
    S_UNC_R   = 3'd5,
    S_RESP    = 3'd6,
    S_INV     = 3'd7
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_words, input int sets);
    return 32 - off_w(line_words) - idx_w(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// icache_if : CPU fetch and AXI read-channel bundles for the icache | rev 1.0
// ============================================================================
interface icache_cpu_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_uncached;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_err;
  logic        inv_req;
  logic        inv_ack;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_uncached, inv_req,
    input  inst_addr_ok, inst_data_ok, inst_rdata, inst_err, inv_ack
  );
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_uncached, inv_req,
    output inst_addr_ok, inst_data_ok, inst_rdata, inst_err, inv_ack
  );
endinterface

interface icache_axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/icache_way_store.sv
`default_nettype none
// ============================================================================
// icache_way_store : one way's tag/valid/data arrays, combinational read | rev 1.0
// ============================================================================
module icache_way_store
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 128,
  parameter int TAG_W      = tag_w(LINE_WORDS, SETS)
)(
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [$clog2(SETS)-1:0]       i_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_word,
  output logic                          o_valid,
  output logic [TAG_W-1:0]              o_tag,
  output logic [31:0]                   o_data,
  input  logic                          i_data_we,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_word,
  input  logic [31:0]                   i_wr_data,
  input  logic                          i_tag_we,
  input  logic [TAG_W-1:0]              i_tag,
  input  logic                          i_valid,
  input  logic                          i_clr_all
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (!resetn || i_clr_all) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_idx] <= i_valid;
    end
  end

  // Payload arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (i_tag_we) begin
      r_tag[i_idx] <= i_tag;
    end
    if (i_data_we) begin
      r_data[{i_idx, i_wr_word}] <= i_wr_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[{i_idx, i_rd_word}];

endmodule
`default_nettype wire

// File: rtl/icache_2way_param.sv
`default_nettype none
// ============================================================================
// icache_2way_param : 2-way set-associative icache, LRU, bypass, invalidate | rev 1.0
// ============================================================================
module icache_2way_param
  import icache_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter int         SETS       = 128,
  parameter logic [3:0] ARID_VAL   = 4'd0
)(
  input  logic         clk,
  input  logic         resetn,
  icache_cpu_if.slave  cpu,
  icache_axi_if.master axi
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(LINE_WORDS, SETS);
  localparam int WRD_W = OFF_W - 2;

  state_t           r_state, w_next;
  logic [31:0]      r_addr;
  logic             r_unc;
  logic             r_victim;
  logic             r_err;
  logic [WRD_W-1:0] r_beat;
  logic [31:0]      r_resp_data;
  logic [SETS-1:0]  r_lru;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [WRD_W-1:0] w_word;
  logic [1:0]       w_way_valid;
  logic [TAG_W-1:0] w_way_tag  [2];
  logic [31:0]      w_way_data [2];
  logic [1:0]       w_hit_way;
  logic             w_hit, w_req_ok, w_beat, w_last, w_beat_err, w_fill_valid;
  logic [31:0]      w_hit_data;

  logic             w_addr_ok, w_data_ok, w_err, w_inv_ack, w_arvalid, w_rready;
  logic [31:0]      w_rdata, w_araddr;
  logic [7:0]       w_arlen;
  logic             w_unused_ok;

  assign w_tag  = r_addr[31 -: TAG_W];
  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_word = r_addr[2 +: WRD_W];

  assign w_beat       = (r_state == S_REFILL) && axi.rvalid;
  assign w_last       = w_beat && axi.rlast;
  assign w_beat_err   = (axi.rresp != RESP_OKAY);
  assign w_fill_valid = !(r_err || w_beat_err);

  generate
    for (genvar w = 0; w < 2; w++) begin : g_way
      icache_way_store #(
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .TAG_W      (TAG_W)
      ) u_store (
        .clk       (clk),
        .resetn    (resetn),
        .i_idx     (w_idx),
        .i_rd_word (w_word),
        .o_valid   (w_way_valid[w]),
        .o_tag     (w_way_tag[w]),
        .o_data    (w_way_data[w]),
        .i_data_we (w_beat && (r_victim == 1'(w))),
        .i_wr_word (r_beat),
        .i_wr_data (axi.rdata),
        .i_tag_we  (w_last && (r_victim == 1'(w))),
        .i_tag     (w_tag),
        .i_valid   (w_fill_valid),
        .i_clr_all (r_state == S_INV)
      );
      assign w_hit_way[w] = w_way_valid[w] && (w_way_tag[w] == w_tag);
    end
  endgenerate

  assign w_hit      = |w_hit_way;
  assign w_hit_data = w_hit_way[1] ? w_way_data[1] : w_way_data[0];
  assign w_req_ok   = cpu.inst_req && !cpu.inst_wr && !cpu.inv_req;

  always_comb begin
    w_next    = r_state;
    w_addr_ok = 1'b0;
    w_data_ok = 1'b0;
    w_rdata   = r_resp_data;
    w_err     = 1'b0;
    w_inv_ack = 1'b0;
    w_arvalid = 1'b0;
    w_araddr  = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
    w_arlen   = 8'(LINE_WORDS - 1);
    w_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu.inv_req) begin
          w_next = S_INV;
        end else if (w_req_ok) begin
          w_addr_ok = 1'b1;
          w_next    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (r_unc) begin
          w_next = S_UNC_AR;
        end else if (w_hit) begin
          w_data_ok = 1'b1;
          w_rdata   = w_hit_data;
          w_addr_ok = w_req_ok;
          w_next    = w_req_ok ? S_LOOKUP : S_IDLE;
        end else begin
          w_next = S_MISS_AR;
        end
      end
      S_MISS_AR: begin
        w_arvalid = 1'b1;
        if (axi.arready) w_next = S_REFILL;
      end
      S_REFILL: begin
        w_rready = 1'b1;
        if (w_last) w_next = S_RESP;
      end
      S_UNC_AR: begin
        w_arvalid = 1'b1;
        w_araddr  = r_addr;
        w_arlen   = 8'd0;
        if (axi.arready) w_next = S_UNC_R;
      end
      S_UNC_R: begin
        w_rready = 1'b1;
        if (axi.rvalid) w_next = S_RESP;
      end
      S_RESP: begin
        w_data_ok = 1'b1;
        w_err     = r_err;
        w_next    = S_IDLE;
      end
      S_INV: begin
        w_inv_ack = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_unc       <= 1'b0;
      r_victim    <= 1'b0;
      r_err       <= 1'b0;
      r_beat      <= '0;
      r_resp_data <= '0;
      r_lru       <= '0;
    end else begin
      r_state <= w_next;
      if (w_addr_ok) begin
        r_addr <= cpu.inst_addr;
        r_unc  <= cpu.inst_uncached;
      end
      // r_lru names the way to evict next; invalid ways always win over it.
      if (r_state == S_LOOKUP && !r_unc) begin
        if (w_hit) begin
          r_lru[w_idx] <= w_hit_way[0];
        end else begin
          r_victim <= w_way_valid[0] ? (w_way_valid[1] ? r_lru[w_idx] : 1'b1) : 1'b0;
        end
      end
      if (w_beat) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
        if (r_beat == w_word) r_resp_data <= axi.rdata;
        if (w_beat_err) r_err <= 1'b1;
        if (w_last) r_lru[w_idx] <= ~r_victim;
      end
      if (r_state == S_UNC_R && axi.rvalid) begin
        r_resp_data <= axi.rdata;
        r_err       <= w_beat_err;
      end
      if (r_state == S_RESP) r_err <= 1'b0;
    end
  end

  assign cpu.inst_addr_ok = w_addr_ok;
  assign cpu.inst_data_ok = w_data_ok;
  assign cpu.inst_rdata   = w_rdata;
  assign cpu.inst_err     = w_err;
  assign cpu.inv_ack      = w_inv_ack;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = w_araddr;
  assign axi.arlen   = w_arlen;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;

  assign w_unused_ok = ^{cpu.inst_size, axi.rid};

endmodule
`default_nettype wire
